hour_bcd_updown_counter: RTL and testbench
==========================================

HOUR_BCD_UPDOWN_COUNTER -- requirements
Module: hour_bcd_updown_counter

Interface
REQ-001: The block SHALL have parameter H12_ZERO_AS_12, default 1, meaning: when 1, hour 00 maps to 12 AM in the 12-hour outputs; when 0, it maps to 00 AM.
REQ-002: The block SHALL have the port clk, input, 1 bit: the single system clock, with rising-edge active.
REQ-003: The block SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004: The block SHALL have the port en, input, 1 bit: count enable; when 0, tick_in is ignored.
REQ-005: The block SHALL have the port tick_in, input, 1 bit: hour step strobe; each high cycle is one step.
REQ-006: The block SHALL have the port dir, input, 1 bit: 1 = count up, 0 = count down; sampled with each tick.
REQ-007: The block SHALL have the port load, input, 1 bit: synchronous time-set strobe.
REQ-008: The block SHALL have the port load_unit, input, 4 bits: BCD hour-units value to load.
REQ-009: The block SHALL have the port load_ten, input, 2 bits: BCD hour-tens value to load.
REQ-010: The block SHALL have the port count_H_unit, output, 4 bits: registered 24-hour units digit, 0-9.
REQ-011: The block SHALL have the port count_H_ten, output, 2 bits: registered 24-hour tens digit, 0-2.
REQ-012: The block SHALL have the port wrap_out, output, 1 bit: one-cycle pulse on the 23->00 (up) or 00->23 (down) rollover.
REQ-013: The block SHALL have the port load_err, output, 1 bit: one-cycle pulse when a load carries an invalid hour.
REQ-014: The block SHALL have the port hr12_unit, output, 4 bits: 12-hour units digit.
REQ-015: The block SHALL have the port hr12_ten, output, 1 bit: 12-hour tens digit.
REQ-016: The block SHALL have the port pm, output, 1 bit: 1 for hours 12-23, 0 for hours 00-11.

Function
REQ-017: The state SHALL be the BCD pair {count_H_ten, count_H_unit}; the only legal values SHALL be 00-23, and no illegal value SHALL ever be reachable.
REQ-018: Priority per rising edge SHALL be: load, then (en && tick_in), then hold.
REQ-019: A valid load SHALL satisfy load_unit<=9 and load_ten<=2, and load_ten==2 SHALL additionally require load_unit<=3.
REQ-020: A valid load SHALL update the count at that edge, with no wrap_out.
REQ-021: An invalid load SHALL hold the count, drop any same-cycle tick, and assert load_err for exactly one cycle after that edge.
REQ-022: Up-step: when units<9 and the hour is not 23, units SHALL increment by 1.
REQ-023: Up-step: when units==9, units SHALL become 0 and tens SHALL increment by 1 (09->10, 19->20).
REQ-024: Up-step: the hour 23 SHALL go to 00, and wrap_out SHALL assert.
REQ-025: Down-step: when units>0, units SHALL decrement by 1.
REQ-026: Down-step: when units==0 and tens>0, units SHALL become 9 and tens SHALL decrement by 1 (20->19, 10->09).
REQ-027: Down-step: the hour 00 SHALL go to 23, and wrap_out SHALL assert.
REQ-028: Latency: a tick or load sampled at edge N SHALL be reflected in the count, wrap_out and load_err immediately after edge N; wrap_out SHALL be registered and coincide with the new count.
REQ-029: wrap_out and load_err SHALL each be high for exactly one cycle per event.
REQ-030: tick_in held high for K consecutive cycles with en=1 SHALL produce K steps.
REQ-031: A dir change between ticks SHALL take effect on the next tick, with no extra step.
REQ-032: The 12-hour outputs SHALL be combinational decodes of the registered count, with zero added latency.
REQ-033: Hours 01-09 SHALL decode as the same value AM.
REQ-034: Hours 10-11 SHALL decode as 10-11 AM.
REQ-035: Hour 12 SHALL decode as 12 PM.
REQ-036: Hours 13-21 SHALL decode as 01-09 PM.
REQ-037: Hours 22-23 SHALL decode as 10-11 PM.
REQ-038: Hour 00 SHALL decode as 12 AM when H12_ZERO_AS_12=1, and as 00 AM when H12_ZERO_AS_12=0.

Reset
REQ-039: While rst_n==0, asynchronously: count SHALL be 00, wrap_out=0, load_err=0, pm=0, hr12 SHALL be 12 (or 00 when H12_ZERO_AS_12=0).
REQ-040: The first edge after rst_n rises SHALL be able to process load or tick normally.
REQ-041: Reset asserted mid-sequence SHALL abort any pending pulse, and no wrap_out SHALL appear after release.

Verification
REQ-042: Reset, then 24 up-ticks with en=1, dir=1 -> count steps 01..23 then 00; wrap_out SHALL pulse once, on the 24th step only.
REQ-043: Reset, then dir=0 and one tick -> count 23, wrap_out pulses; the next tick -> 22; ticks from 20 -> 19, and from 10 -> 09.
REQ-044: Load 2/4 (hour 24) together with tick_in=1 -> count holds, load_err pulses one cycle, no step; load 2/3 -> count 23, no load_err.
REQ-045: At count 23 with load=1 (value 05), tick_in=1, dir=1 -> count 05, wrap_out stays 0.
REQ-046: Sweep 00-23 with H12_ZERO_AS_12=1 -> 00 = 12 AM, 11 = 11 AM, 12 = 12 PM, 13 = 01 PM, 23 = 11 PM; with H12_ZERO_AS_12=0, 00 = 00 AM.
REQ-047: en=0 with a tick -> no change; rst_n pulled low mid-cycle at count 17 -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hour_bcd_updown_counter.sv
// BCD hour counter (00-23), up/down with synchronous load and a 12-hour decode.
// One-cycle latency for count and pulse outputs; no backpressure (every tick is accepted).
module hour_bcd_updown_counter #(
  parameter bit H12_ZERO_AS_12 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick_in,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_unit,
  input  logic [1:0] load_ten,
  output logic [3:0] count_H_unit,
  output logic [1:0] count_H_ten,
  output logic       wrap_out,
  output logic       load_err,
  output logic [3:0] hr12_unit,
  output logic       hr12_ten,
  output logic       pm
);

  logic [3:0] unit_q, unit_d;
  logic [1:0] ten_q, ten_d;
  logic       wrap_q, wrap_d;
  logic       err_q, err_d;

  logic       load_ok;
  logic       step;
  logic       at_max;
  logic       at_min;
  logic [3:0] up_unit, dn_unit;
  logic [1:0] up_ten, dn_ten;

  // Tens value 3 is never legal, and tens 2 only allows units 0-3.
  assign load_ok = (load_unit <= 4'd9) && (load_ten != 2'd3) &&
                   !((load_ten == 2'd2) && (load_unit > 4'd3));
  assign step    = en && tick_in && !load;
  assign at_max  = (ten_q == 2'd2) && (unit_q == 4'd3);
  assign at_min  = (ten_q == 2'd0) && (unit_q == 4'd0);

  always_comb begin
    up_unit = unit_q;
    up_ten  = ten_q;
    if (at_max) begin
      up_unit = 4'd0;
      up_ten  = 2'd0;
    end else if (unit_q == 4'd9) begin
      up_unit = 4'd0;
      up_ten  = ten_q + 2'd1;
    end else begin
      up_unit = unit_q + 4'd1;
    end
  end

  always_comb begin
    dn_unit = unit_q;
    dn_ten  = ten_q;
    if (unit_q != 4'd0) begin
      dn_unit = unit_q - 4'd1;
    end else if (ten_q != 2'd0) begin
      dn_unit = 4'd9;
      dn_ten  = ten_q - 2'd1;
    end else begin
      dn_unit = 4'd3;
      dn_ten  = 2'd2;
    end
  end

  // Load wins over a same-cycle tick; an invalid load also swallows that tick.
  always_comb begin
    unit_d = unit_q;
    ten_d  = ten_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_ok) begin
        unit_d = load_unit;
        ten_d  = load_ten;
      end else begin
        err_d = 1'b1;
      end
    end else if (step) begin
      if (dir) begin
        unit_d = up_unit;
        ten_d  = up_ten;
        wrap_d = at_max;
      end else begin
        unit_d = dn_unit;
        ten_d  = dn_ten;
        wrap_d = at_min;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_q <= 4'd0;
      ten_q  <= 2'd0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unit_q <= unit_d;
      ten_q  <= ten_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign count_H_unit = unit_q;
  assign count_H_ten  = ten_q;
  assign wrap_out     = wrap_q;
  assign load_err     = err_q;

  // 12-hour view is a pure decode of the registered count.
  always_comb begin
    pm        = (ten_q == 2'd2) || ((ten_q == 2'd1) && (unit_q >= 4'd2));
    hr12_ten  = 1'b0;
    hr12_unit = unit_q;
    if (at_min) begin
      hr12_ten  = H12_ZERO_AS_12;
      hr12_unit = H12_ZERO_AS_12 ? 4'd2 : 4'd0;
    end else if (!pm) begin
      hr12_ten  = ten_q[0];
      hr12_unit = unit_q;
    end else if ((ten_q == 2'd1) && (unit_q == 4'd2)) begin
      hr12_ten  = 1'b1;
      hr12_unit = 4'd2;
    end else if (ten_q == 2'd1) begin
      hr12_unit = unit_q - 4'd2;
    end else if (unit_q <= 4'd1) begin
      hr12_unit = unit_q + 4'd8;
    end else begin
      hr12_ten  = 1'b1;
      hr12_unit = unit_q - 4'd2;
    end
  end

endmodule

// File: tb/tb_hour_bcd_updown_counter.sv
// Bench for hour_bcd_updown_counter: directed literal checks plus randomized traffic
// compared every cycle against an integer-hour reference model.
module tb_hour_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, tick_in = 1'b0, dir = 1'b1, load = 1'b0;
  logic [3:0] load_unit = 4'd0;
  logic [1:0] load_ten = 2'd0;

  logic [3:0] cu_a, hu_a, cu_b, hu_b;
  logic [1:0] ct_a, ct_b;
  logic       wr_a, er_a, ht_a, pm_a, wr_b, er_b, ht_b, pm_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  int m_hour = 0;
  bit m_wrap = 1'b0;
  bit m_err = 1'b0;

  hour_bcd_updown_counter #(.H12_ZERO_AS_12(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_in(tick_in), .dir(dir), .load(load),
    .load_unit(load_unit), .load_ten(load_ten), .count_H_unit(cu_a), .count_H_ten(ct_a),
    .wrap_out(wr_a), .load_err(er_a), .hr12_unit(hu_a), .hr12_ten(ht_a), .pm(pm_a));

  hour_bcd_updown_counter #(.H12_ZERO_AS_12(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_in(tick_in), .dir(dir), .load(load),
    .load_unit(load_unit), .load_ten(load_ten), .count_H_unit(cu_b), .count_H_ten(ct_b),
    .wrap_out(wr_b), .load_err(er_b), .hr12_unit(hu_b), .hr12_ten(ht_b), .pm(pm_b));

  always #5 clk = ~clk;

  // Reference model: the hour as a plain integer 0..23.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hour <= 0;
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
      if (load) begin
        if (load_unit <= 9 && (int'(load_ten) * 10 + int'(load_unit)) <= 23)
          m_hour <= int'(load_ten) * 10 + int'(load_unit);
        else
          m_err <= 1'b1;
      end else if (en && tick_in) begin
        if (dir) begin
          m_wrap <= (m_hour == 23);
          m_hour <= (m_hour + 1) % 24;
        end else begin
          m_wrap <= (m_hour == 0);
          m_hour <= (m_hour + 23) % 24;
        end
      end
    end
  end

  function automatic int h12_of(input int h, input bit zero_as_12);
    int r;
    r = h % 12;
    if (r == 0 && (h == 12 || zero_as_12)) r = 12;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("a_ten",   int'(ct_a), m_hour / 10);
      chk("a_unit",  int'(cu_a), m_hour % 10);
      chk("a_wrap",  int'(wr_a), int'(m_wrap));
      chk("a_err",   int'(er_a), int'(m_err));
      chk("a_hr12",  int'(ht_a) * 10 + int'(hu_a), h12_of(m_hour, 1'b1));
      chk("a_pm",    int'(pm_a), int'(m_hour >= 12));
      chk("b_hour",  int'(ct_b) * 10 + int'(cu_b), m_hour);
      chk("b_wrap",  int'(wr_b), int'(m_wrap));
      chk("b_err",   int'(er_b), int'(m_err));
      chk("b_hr12",  int'(ht_b) * 10 + int'(hu_b), h12_of(m_hour, 1'b0));
      chk("b_pm",    int'(pm_b), int'(m_hour >= 12));
    end
  end

  // Drive one cycle of inputs from a negedge; optionally pulse reset before the edge.
  task automatic cyc(input bit e, input bit t, input bit d, input bit l,
                     input int lt, input int lu, input bit rst_pulse);
    en = e; tick_in = t; dir = d; load = l;
    load_ten = 2'(lt); load_unit = 4'(lu);
    if (rst_pulse) begin
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic int hr_a();
    return int'(ct_a) * 10 + int'(cu_a);
  endfunction

  task automatic reset_reads_literal(input string tag);
    chk({tag, "_hour"}, hr_a(), 0);
    chk({tag, "_wrap"}, int'(wr_a), 0);
    chk({tag, "_err"},  int'(er_a), 0);
    chk({tag, "_pm"},   int'(pm_a), 0);
    chk({tag, "_hr12"}, int'(ht_a) * 10 + int'(hu_a), 12);
    chk({tag, "_hr12z"}, int'(ht_b) * 10 + int'(hu_b), 0);
  endtask

  initial begin
    int wraps;
    repeat (2) @(negedge clk);
    reset_reads_literal("in_reset");
    rst_n = 1'b1;
    run_chk = 1'b1;

    // Full up-count around the clock.
    wraps = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, 1, 1, 0, 0, 0, 0);
      wraps += int'(wr_a);
      if (i == 1)  chk("up_first", hr_a(), 1);
      if (i == 23) chk("up_23", hr_a(), 23);
      if (i == 23) chk("up_23_hr12", int'(ht_a) * 10 + int'(hu_a), 11);
      if (i == 24) chk("up_wrap_hour", hr_a(), 0);
      if (i == 24) chk("up_wrap_pulse", int'(wr_a), 1);
    end
    chk("up_wrap_count", wraps, 1);

    // Down-count boundaries.
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("dn_00_to_23", hr_a(), 23);
    chk("dn_wrap", int'(wr_a), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("dn_22", hr_a(), 22);
    chk("dn_wrap_gone", int'(wr_a), 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("dn_20_19", hr_a(), 19);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("dn_10_09", hr_a(), 9);

    // Invalid load with a tick: hold, one-cycle error.
    cyc(1, 1, 1, 1, 2, 4, 0);
    chk("bad_load_hold", hr_a(), 9);
    chk("bad_load_err", int'(er_a), 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("bad_load_err_1cyc", int'(er_a), 0);
    cyc(0, 0, 1, 1, 2, 3, 0);
    chk("load_23", hr_a(), 23);
    chk("load_23_err", int'(er_a), 0);
    cyc(1, 1, 1, 1, 0, 5, 0);
    chk("load_over_tick", hr_a(), 5);
    chk("load_no_wrap", int'(wr_a), 0);

    // 12-hour decode spot checks.
    cyc(0, 0, 1, 1, 1, 1, 0);
    chk("h11_hr12", int'(ht_a) * 10 + int'(hu_a), 11);
    chk("h11_pm", int'(pm_a), 0);
    cyc(0, 0, 1, 1, 1, 2, 0);
    chk("h12_hr12", int'(ht_a) * 10 + int'(hu_a), 12);
    chk("h12_pm", int'(pm_a), 1);
    cyc(0, 0, 1, 1, 1, 3, 0);
    chk("h13_hr12", int'(ht_a) * 10 + int'(hu_a), 1);
    chk("h13_pm", int'(pm_a), 1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("h00_hr12", int'(ht_a) * 10 + int'(hu_a), 12);
    chk("h00_hr12_z", int'(ht_b) * 10 + int'(hu_b), 0);

    // en=0 ignores ticks; then asynchronous reset mid-cycle at 17.
    cyc(0, 0, 1, 1, 1, 7, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("en0_hold", hr_a(), 17);
    #2 rst_n = 1'b0;
    #1 reset_reads_literal("async_rst");
    #1 rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("post_rst_no_wrap", int'(wr_a), 0);

    // Reset during a live wrap pulse aborts it.
    cyc(0, 0, 1, 1, 2, 3, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("pulse_before_rst", int'(wr_a), 1);
    #1 rst_n = 1'b0;
    #1 chk("pulse_aborted", int'(wr_a), 0);
    #1 rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pulse_stays_low", int'(wr_a), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit l, e, t, rp;
      l  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 7) != 0);
      t  = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      cyc(e, t, dir, l, $urandom_range(0, 3), $urandom_range(0, 11), rp);
    end

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
